// File: rtl/alu_pipe_if.sv
// Handshake and data bundle between the operand source, the pipelined ALU and the result consumer.
// Signal names keep the ALU's point of view (i_ = into the ALU, o_ = out of the ALU).
interface alu_pipe_if #(
  parameter int NB_OP   = 6,
  parameter int NB_DATA = 8
);
  logic               i_valid;
  logic               o_ready;
  logic [NB_OP-1:0]   i_op;
  logic [NB_DATA-1:0] i_data_A;
  logic [NB_DATA-1:0] i_data_B;
  logic               o_valid;
  logic               i_ready;
  logic [NB_DATA-1:0] o_data;
  logic               o_zero;
  logic               o_neg;
  logic               o_carry;
  logic               o_ovf;
  logic               o_err;

  modport master (
    output i_valid, i_op, i_data_A, i_data_B, i_ready,
    input  o_ready, o_valid, o_data, o_zero, o_neg, o_carry, o_ovf, o_err
  );

  modport slave (
    input  i_valid, i_op, i_data_A, i_data_B, i_ready,
    output o_ready, o_valid, o_data, o_zero, o_neg, o_carry, o_ovf, o_err
  );
endinterface

// File: rtl/alu_pipe.sv
// Pipelined ALU: result and flags are computed combinationally at the input and then carried
// through LATENCY register stages; a stalled output freezes the whole pipeline.
module alu_pipe #(
  parameter int NB_OP   = 6,
  parameter int NB_DATA = 8,
  parameter int LATENCY = 2
) (
  input logic        i_clk,
  input logic        i_reset,
  alu_pipe_if.slave  bus
);

  localparam int NB_PK = NB_DATA + 5;

  localparam logic [NB_OP-1:0] OP_ADD  = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OP_SUB  = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] OP_AND  = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OP_OR   = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OP_XOR  = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] OP_NOR  = NB_OP'(6'b100111);
  localparam logic [NB_OP-1:0] OP_SLL  = NB_OP'(6'b000000);
  localparam logic [NB_OP-1:0] OP_SRL  = NB_OP'(6'b000010);
  localparam logic [NB_OP-1:0] OP_SRA  = NB_OP'(6'b000011);
  localparam logic [NB_OP-1:0] OP_SLT  = NB_OP'(6'b101010);
  localparam logic [NB_OP-1:0] OP_SLTU = NB_OP'(6'b101011);

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("alu_pipe: LATENCY must be in 1..4");
  end
  if (NB_DATA < 2) begin : g_bad_width
    $error("alu_pipe: NB_DATA must be >= 2");
  end

  logic [NB_DATA-1:0] w_a;
  logic [NB_DATA-1:0] w_b;
  logic [NB_DATA:0]   w_add;
  logic [NB_DATA:0]   w_sub;
  logic [NB_DATA-1:0] w_res;
  logic               w_carry;
  logic               w_ovf;
  logic               w_err;
  logic               w_zero;
  logic               w_neg;
  logic [NB_PK-1:0]   w_pk;
  logic               w_en;

  logic [LATENCY-1:0] r_vld;
  logic [NB_PK-1:0]   r_pk [LATENCY];

  assign w_a   = bus.i_data_A;
  assign w_b   = bus.i_data_B;
  // Extra top bit is the unsigned carry out (ADD) or borrow (SUB).
  assign w_add = {1'b0, w_a} + {1'b0, w_b};
  assign w_sub = {1'b0, w_a} - {1'b0, w_b};

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_err   = 1'b0;
    case (bus.i_op)
      OP_ADD: begin
        w_res   = w_add[NB_DATA-1:0];
        w_carry = w_add[NB_DATA];
        w_ovf   = (w_a[NB_DATA-1] == w_b[NB_DATA-1]) && (w_add[NB_DATA-1] != w_a[NB_DATA-1]);
      end
      OP_SUB: begin
        w_res   = w_sub[NB_DATA-1:0];
        w_carry = w_sub[NB_DATA];
        w_ovf   = (w_a[NB_DATA-1] != w_b[NB_DATA-1]) && (w_sub[NB_DATA-1] != w_a[NB_DATA-1]);
      end
      OP_AND:  w_res = w_a & w_b;
      OP_OR:   w_res = w_a | w_b;
      OP_XOR:  w_res = w_a ^ w_b;
      OP_NOR:  w_res = ~(w_a | w_b);
      // Shift amounts >= NB_DATA yield zero / sign fill by the language's shift semantics.
      OP_SLL:  w_res = w_a << w_b;
      OP_SRL:  w_res = w_a >> w_b;
      OP_SRA:  w_res = $signed(w_a) >>> w_b;
      OP_SLT:  w_res = NB_DATA'($signed(w_a) < $signed(w_b));
      OP_SLTU: w_res = NB_DATA'(w_a < w_b);
      default: w_err = 1'b1;
    endcase
  end

  assign w_zero = (w_res == '0);
  assign w_neg  = w_res[NB_DATA-1];
  assign w_pk   = {w_err, w_ovf, w_carry, w_neg, w_zero, w_res};

  assign w_en = !r_vld[LATENCY-1] || bus.i_ready;

  // Bubbles carry all-zero payload so idle output stages read back as zero.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vld <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_pk[i] <= '0;
      end
    end else if (w_en) begin
      r_vld[0] <= bus.i_valid;
      r_pk[0]  <= bus.i_valid ? w_pk : '0;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_pk[i]  <= r_pk[i-1];
      end
    end
  end

  assign bus.o_ready = w_en;
  assign bus.o_valid = r_vld[LATENCY-1];
  assign {bus.o_err, bus.o_ovf, bus.o_carry, bus.o_neg, bus.o_zero, bus.o_data} = r_pk[LATENCY-1];

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench: three ALU instances (8b/L2, 16b/L1, 16b/L4) share one stimulus stream;
// a per-instance scoreboard checks results, latency, ready rule and output hold under stall.
module tb_alu_pipe;

  typedef struct packed {
    logic [15:0] data;
    logic        err;
    logic        ovf;
    logic        carry;
    logic        neg;
    logic        zero;
  } res_t;

  typedef struct {
    res_t r;
    int   acc_cyc;
    int   acc_stall;
  } sb_t;

  typedef struct {
    logic [5:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    res_t        e8;
    bit          has16;
    res_t        e16;
  } vec_t;

  localparam logic [5:0] ADD = 6'h20, SUB = 6'h22, AND_ = 6'h24, OR_ = 6'h25, XOR_ = 6'h26;
  localparam logic [5:0] NOR_ = 6'h27, SLL = 6'h00, SRL = 6'h02, SRA = 6'h03;
  localparam logic [5:0] SLT = 6'h2A, SLTU = 6'h2B, ILL = 6'h3F;

  logic        clk = 1'b0;
  logic        t_reset = 1'b1;
  logic        t_valid = 1'b0;
  logic        t_ready = 1'b1;
  logic [5:0]  t_op = '0;
  logic [15:0] t_a = '0;
  logic [15:0] t_b = '0;
  res_t        cur_e8 = '0;
  res_t        cur_e16 = '0;
  bit          cur_has16 = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int stalls [3] = '{0, 0, 0};
  bit have_hold [3] = '{0, 0, 0};
  logic [20:0] hold_val [3];
  sb_t sb_q [3][$];
  vec_t tbl [21];

  always #5 clk = ~clk;

  alu_pipe_if #(.NB_OP(6), .NB_DATA(8))  if0 ();
  alu_pipe_if #(.NB_OP(6), .NB_DATA(16)) if1 ();
  alu_pipe_if #(.NB_OP(6), .NB_DATA(16)) if2 ();

  alu_pipe #(.NB_OP(6), .NB_DATA(8),  .LATENCY(2)) u_dut0 (.i_clk(clk), .i_reset(t_reset), .bus(if0.slave));
  alu_pipe #(.NB_OP(6), .NB_DATA(16), .LATENCY(1)) u_dut1 (.i_clk(clk), .i_reset(t_reset), .bus(if1.slave));
  alu_pipe #(.NB_OP(6), .NB_DATA(16), .LATENCY(4)) u_dut2 (.i_clk(clk), .i_reset(t_reset), .bus(if2.slave));

  assign if0.i_valid = t_valid;  assign if0.i_ready = t_ready;  assign if0.i_op = t_op;
  assign if0.i_data_A = t_a[7:0]; assign if0.i_data_B = t_b[7:0];
  assign if1.i_valid = t_valid;  assign if1.i_ready = t_ready;  assign if1.i_op = t_op;
  assign if1.i_data_A = t_a;     assign if1.i_data_B = t_b;
  assign if2.i_valid = t_valid;  assign if2.i_ready = t_ready;  assign if2.i_op = t_op;
  assign if2.i_data_A = t_a;     assign if2.i_data_B = t_b;

  logic        m_valid [3];
  logic        m_ready [3];
  logic [15:0] m_data  [3];
  logic [4:0]  m_flags [3];

  assign m_valid[0] = if0.o_valid; assign m_ready[0] = if0.o_ready; assign m_data[0] = {8'h00, if0.o_data};
  assign m_flags[0] = {if0.o_err, if0.o_ovf, if0.o_carry, if0.o_neg, if0.o_zero};
  assign m_valid[1] = if1.o_valid; assign m_ready[1] = if1.o_ready; assign m_data[1] = if1.o_data;
  assign m_flags[1] = {if1.o_err, if1.o_ovf, if1.o_carry, if1.o_neg, if1.o_zero};
  assign m_valid[2] = if2.o_valid; assign m_ready[2] = if2.o_ready; assign m_data[2] = if2.o_data;
  assign m_flags[2] = {if2.o_err, if2.o_ovf, if2.o_carry, if2.o_neg, if2.o_zero};

  function automatic int lat_of(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic res_t mk(input logic [15:0] d, input bit e, input bit v, input bit c, input bit n, input bit z);
    res_t r;
    r.data = d; r.err = e; r.ovf = v; r.carry = c; r.neg = n; r.zero = z;
    return r;
  endfunction

  // Integer reference model of the ALU for width w.
  function automatic res_t model(input logic [5:0] op, input logic [15:0] ai, input logic [15:0] bi, input int w);
    res_t r;
    longint mask, half, a, b, sa, sb, s;
    logic [15:0] d;
    r = '0;
    mask = (64'sd1 <<< w) - 1;
    half = (mask + 1) / 2;
    a = longint'(ai) & mask;
    b = longint'(bi) & mask;
    sa = (a >= half) ? a - (mask + 1) : a;
    sb = (b >= half) ? b - (mask + 1) : b;
    s = 0;
    case (op)
      ADD:  begin s = a + b; r.carry = (s > mask); r.ovf = ((sa + sb) >= half) || ((sa + sb) < -half); end
      SUB:  begin s = a - b; r.carry = (a < b);    r.ovf = ((sa - sb) >= half) || ((sa - sb) < -half); end
      AND_: s = a & b;
      OR_:  s = a | b;
      XOR_: s = a ^ b;
      NOR_: s = ~(a | b);
      SLL:  s = (b >= longint'(w)) ? 0 : (a << b);
      SRL:  s = (b >= longint'(w)) ? 0 : (a >> b);
      SRA:  s = (b >= longint'(w)) ? ((sa < 0) ? mask : 0) : (sa >>> b);
      SLT:  s = (sa < sb) ? 1 : 0;
      SLTU: s = (a < b) ? 1 : 0;
      default: begin s = 0; r.err = 1'b1; end
    endcase
    d = 16'(s & mask);
    r.data = d;
    r.zero = (d == 16'h0000);
    r.neg  = d[w-1];
    return r;
  endfunction

  function automatic vec_t V(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b, input res_t e8);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.e8 = e8; v.has16 = 1'b0; v.e16 = '0;
    return v;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", name, k, act, exp);
    end
  endtask

  // Scoreboard / monitor; sampled at the falling edge, where inputs and outputs are settled.
  always @(negedge clk) begin
    sb_t it;
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (t_reset) begin
        sb_q[k].delete();
        have_hold[k] = 1'b0;
      end else begin
        chk("ready_rule", k, 32'(m_ready[k]), 32'(!m_valid[k] || t_ready));
        if (have_hold[k])
          chk("hold_stable", k, 32'({m_valid[k], m_data[k], m_flags[k]}), 32'({1'b1, hold_val[k]}));
        if (m_valid[k] && t_ready) begin
          if (sb_q[k].size() == 0) begin
            chk("unexpected_output", k, 32'(m_valid[k]), 32'd0);
          end else begin
            it = sb_q[k].pop_front();
            chk("result", k, 32'({m_data[k], m_flags[k]}), 32'(it.r));
            chk("latency", k, 32'(cyc - it.acc_cyc), 32'(lat_of(k) + stalls[k] - it.acc_stall));
          end
        end
        if (t_valid && m_ready[k]) begin
          if (k == 0) it.r = cur_e8;
          else        it.r = cur_has16 ? cur_e16 : model(t_op, t_a, t_b, 16);
          it.acc_cyc   = cyc;
          it.acc_stall = stalls[k];
          sb_q[k].push_back(it);
        end
        if (m_valid[k] && !t_ready) begin
          stalls[k]++;
          have_hold[k] = 1'b1;
          hold_val[k]  = {m_data[k], m_flags[k]};
        end else begin
          have_hold[k] = 1'b0;
        end
      end
    end
  end

  // Present one op until the 8-bit instance takes it; callers chain calls for back-to-back traffic.
  task automatic drive(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                       input res_t e8, input bit h16, input res_t e16);
    bit acc;
    acc = 1'b0;
    t_valid = 1'b1; t_op = op; t_a = a; t_b = b;
    cur_e8 = e8; cur_has16 = h16; cur_e16 = e16;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = m_ready[0];
      @(posedge clk); #1;
    end
    if (!acc) chk("accept_timeout", 0, 32'(acc), 32'd1);
    t_valid = 1'b0;
  endtask

  task automatic drive_model(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
    drive(op, a, b, model(op, a, b, 8), 1'b0, '0);
  endtask

  task automatic drain();
    bit empty;
    empty = 1'b0;
    t_valid = 1'b0;
    for (int n = 0; n < 30 && !empty; n++) begin
      @(negedge clk);
      empty = (sb_q[0].size() == 0) && (sb_q[1].size() == 0) && (sb_q[2].size() == 0);
    end
    for (int k = 0; k < 3; k++) chk("drain_empty", k, 32'(sb_q[k].size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    tbl[0]  = V(ADD,  16'h007F, 16'h0001, mk(16'h80, 0, 1, 0, 1, 0));
    tbl[1]  = V(SUB,  16'h0000, 16'h0001, mk(16'hFF, 0, 0, 1, 1, 0));
    tbl[2]  = V(AND_, 16'hFFF0, 16'h003C, mk(16'h30, 0, 0, 0, 0, 0));
    tbl[3]  = V(OR_,  16'hFFF0, 16'h000C, mk(16'hFC, 0, 0, 0, 1, 0));
    tbl[4]  = V(XOR_, 16'hFFFF, 16'hFFFF, mk(16'h00, 0, 0, 0, 0, 1));
    tbl[5]  = V(NOR_, 16'h0000, 16'h0000, mk(16'hFF, 0, 0, 0, 1, 0));
    tbl[6]  = V(ADD,  16'h7FFF, 16'h0001, mk(16'h00, 0, 0, 1, 0, 1));
    tbl[6].has16 = 1'b1;
    tbl[6].e16   = mk(16'h8000, 0, 1, 0, 1, 0);
    tbl[7]  = V(SUB,  16'hFF80, 16'h0001, mk(16'h7F, 0, 1, 0, 0, 0));
    tbl[8]  = V(SRA,  16'hFF90, 16'h0002, mk(16'hE4, 0, 0, 0, 1, 0));
    tbl[9]  = V(SRL,  16'hFF90, 16'h0002, mk(16'h24, 0, 0, 0, 0, 0));
    tbl[10] = V(SLL,  16'hFF90, 16'h0002, mk(16'h40, 0, 0, 0, 0, 0));
    tbl[11] = V(SRA,  16'hFF90, 16'h0009, mk(16'hFF, 0, 0, 0, 1, 0));
    tbl[12] = V(SRL,  16'hFF90, 16'h0009, mk(16'h00, 0, 0, 0, 0, 1));
    tbl[13] = V(SLL,  16'hFF90, 16'h0009, mk(16'h00, 0, 0, 0, 0, 1));
    tbl[14] = V(SRA,  16'hFF90, 16'h0000, mk(16'h90, 0, 0, 0, 1, 0));
    tbl[15] = V(SRL,  16'hFF90, 16'h0000, mk(16'h90, 0, 0, 0, 1, 0));
    tbl[16] = V(SLL,  16'hFF90, 16'h0000, mk(16'h90, 0, 0, 0, 1, 0));
    tbl[17] = V(SLT,  16'hFFFE, 16'h0001, mk(16'h01, 0, 0, 0, 0, 0));
    tbl[18] = V(SLTU, 16'hFFFE, 16'h0001, mk(16'h00, 0, 0, 0, 0, 1));
    tbl[19] = V(ILL,  16'hFFFE, 16'h0001, mk(16'h00, 1, 0, 0, 0, 1));
    tbl[20] = V(ADD,  16'h0001, 16'h0001, mk(16'h02, 0, 0, 0, 0, 0));

    repeat (3) @(posedge clk);
    #1 t_reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk("reset_state", k, 32'({m_valid[k], m_data[k], m_flags[k]}), 32'd0);
    @(posedge clk); #1;

    // Back-to-back vectors with the consumer always ready.
    for (int i = 0; i < 21; i++)
      drive(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e8, tbl[i].has16, tbl[i].e16);
    drain();

    // Backpressure: consumer stalls three cycles while new ops keep arriving.
    t_ready = 1'b1;
    fork
      begin
        for (int n = 1; n <= 8; n++)
          drive_model((n % 3 == 0) ? XOR_ : ((n % 3 == 1) ? ADD : SUB), 16'(n * 37), 16'(n * 5 + 1));
      end
      begin
        for (int n = 0; n < 30 && !m_valid[0]; n++) @(negedge clk);
        chk("bp_seen_valid", 0, 32'(m_valid[0]), 32'd1);
        @(posedge clk); #1 t_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
          @(negedge clk);
          chk("bp_ready_low", 0, 32'(m_ready[0]), 32'd0);
          @(posedge clk); #1;
        end
        t_ready = 1'b1;
      end
    join
    drain();

    // Reset one cycle after accepting ADD 5+3: the result must never appear.
    drive_model(ADD, 16'h0005, 16'h0003);
    t_reset = 1'b1;
    @(posedge clk); #1 t_reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk("reset_midflight_outputs", k, 32'({m_valid[k], m_data[k], m_flags[k]}), 32'd0);
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) chk("reset_midflight_no_valid", k, 32'(m_valid[k]), 32'd0);
    end

    // Streaming resumes cleanly after the reset.
    @(posedge clk); #1;
    drive(tbl[0].op, tbl[0].a, tbl[0].b, tbl[0].e8, tbl[0].has16, tbl[0].e16);
    drive(tbl[6].op, tbl[6].a, tbl[6].b, tbl[6].e8, tbl[6].has16, tbl[6].e16);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
